// File: rtl/trigger_capture_ctrl.sv
// trigger_capture_ctrl: capture sequencer between the trigger block's
// sample stream and the sample memory writer.
// It arms on a bus command and forwards a pre-trigger fill. It then waits
// for the trigger event, forwards the programmed post-trigger samples, and
// marks the final beat with tlast. Samples outside a capture are consumed
// and dropped, so the trigger pipeline never stalls.
// Optional feature: define TRIGGER_CAPTURE_CTRL_TIMEOUT_EN to add the
// TIMEOUT register (addr 3) and force-trigger after cfg_tmo ARMED samples.
module trigger_capture_ctrl #(
  parameter int BAW = 6,
  parameter int BDW = 32,
  parameter int SDW = 32,
  parameter int SEW = 2,
  parameter int CW  = 32
) (
  input  logic           clk,
  input  logic           rst,
  output logic           bus_wready,
  input  logic           bus_wvalid,
  input  logic [BAW-1:0] bus_waddr,
  input  logic [BDW-1:0] bus_wdata,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [SEW-1:0] sti_tevent,
  input  logic [SDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic           sto_tlast,
  output logic [SDW-1:0] sto_tdata,
  output logic [2:0]     sts_state,
  output logic           sts_trig,
  output logic           sts_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [CW-1:0] ONE = CW'(1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cfg_pre;
  logic [CW-1:0] cfg_post;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          wr_ctrl;
  logic          cmd_arm;
  logic          cmd_abort;
  logic          forwarding;
  logic          xfer;
  logic          load;
  logic          load_last;
  logic          trig_next;
  logic          tmo_hit;
  logic          unused_bits;

  // Upper address bits, data bits above CW and extra event bits carry no meaning.
  assign unused_bits = ^{bus_waddr, bus_wdata, sti_tevent};

  assign bus_wready = 1'b1;

  // CTRL writes are one-shot commands; ABORT has priority over ARM.
  assign wr_ctrl   = bus_wvalid && (bus_waddr[1:0] == 2'd0);
  assign cmd_arm   = wr_ctrl & bus_wdata[0];
  assign cmd_abort = wr_ctrl & bus_wdata[1];

  // Outside a capture the input is always accepted (and dropped).
  assign forwarding = (state == FILL) || (state == ARMED) || (state == POST);
  assign sti_tready = forwarding ? (sto_tready | ~sto_tvalid) : 1'b1;
  assign xfer       = sti_tvalid & sti_tready;

  assign sts_state = state;
  assign sts_done  = (state == DONE);

`ifdef TRIGGER_CAPTURE_CTRL_TIMEOUT_EN
  logic [CW-1:0] cfg_tmo;
  logic [CW-1:0] tmo_cnt;

  assign tmo_hit = (cfg_tmo != '0) && (tmo_cnt == cfg_tmo - ONE);

  // Timeout counter: held at zero outside ARMED so it starts fresh on entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state != ARMED) begin
      tmo_cnt <= '0;
    end else if (xfer) begin
      tmo_cnt <= tmo_cnt + ONE;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Configuration registers, writable at any time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_pre  <= '0;
      cfg_post <= '0;
`ifdef TRIGGER_CAPTURE_CTRL_TIMEOUT_EN
      cfg_tmo  <= '0;
`endif
    end else if (bus_wvalid) begin
      case (bus_waddr[1:0])
        2'd1: cfg_pre  <= bus_wdata[CW-1:0];
        2'd2: cfg_post <= bus_wdata[CW-1:0];
`ifdef TRIGGER_CAPTURE_CTRL_TIMEOUT_EN
        2'd3: cfg_tmo  <= bus_wdata[CW-1:0];
`endif
        default: ;
      endcase
    end
  end

  // State and sample counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; decides whether the accepted sample is forwarded and tagged.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load       = 1'b0;
    load_last  = 1'b0;
    trig_next  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (cmd_arm) begin
          state_next = (cfg_pre != '0) ? FILL : ARMED;
          cnt_next   = '0;
        end
      end
      FILL: begin
        if (xfer) begin
          load = 1'b1;
          // Equality exit means cfg_pre of all ones never wraps cnt.
          if (cnt == cfg_pre - ONE) begin
            state_next = ARMED;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + ONE;
          end
        end
      end
      ARMED: begin
        if (xfer) begin
          load = 1'b1;
          if (sti_tevent[0] | tmo_hit) begin
            trig_next = 1'b1;
            cnt_next  = '0;
            if ((cfg_post == '0) || sti_tevent[1]) begin
              load_last  = 1'b1;
              state_next = DONE;
            end else begin
              state_next = POST;
            end
          end
        end
      end
      POST: begin
        if (xfer) begin
          load = 1'b1;
          if ((cnt == cfg_post - ONE) || sti_tevent[1]) begin
            load_last  = 1'b1;
            state_next = DONE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + ONE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // Abort drops the sample of this cycle but leaves the output beat alone.
    if (cmd_abort) begin
      state_next = IDLE;
      cnt_next   = '0;
      load       = 1'b0;
      load_last  = 1'b0;
      trig_next  = 1'b0;
    end
  end

  // Single output register stage; contents hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sto_tvalid <= 1'b0;
      sto_tlast  <= 1'b0;
      sto_tdata  <= '0;
    end else if (load) begin
      sto_tvalid <= 1'b1;
      sto_tlast  <= load_last;
      sto_tdata  <= sti_tdata;
    end else if (sto_tready) begin
      sto_tvalid <= 1'b0;
    end
  end

  // Trigger pulse, one cycle after the trigger sample transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sts_trig <= 1'b0;
    end else begin
      sts_trig <= trig_next;
    end
  end

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Self-checking bench for trigger_capture_ctrl: a directed vector table plus
// hand-written sequences for backpressure, asynchronous reset and the
// optional timeout (TRIGGER_CAPTURE_CTRL_TIMEOUT_EN).
module tb_trigger_capture_ctrl;

  localparam logic [2:0] S_I = 3'd0, S_F = 3'd1, S_A = 3'd2, S_P = 3'd3, S_D = 3'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_wready;
  logic        bus_wvalid;
  logic [5:0]  bus_waddr;
  logic [31:0] bus_wdata;
  logic        sti_tready;
  logic        sti_tvalid;
  logic [1:0]  sti_tevent;
  logic [31:0] sti_tdata;
  logic        sto_tready;
  logic        sto_tvalid;
  logic        sto_tlast;
  logic [31:0] sto_tdata;
  logic [2:0]  sts_state;
  logic        sts_trig;
  logic        sts_done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  trigger_capture_ctrl dut (
    .clk(clk), .rst(rst),
    .bus_wready(bus_wready), .bus_wvalid(bus_wvalid), .bus_waddr(bus_waddr), .bus_wdata(bus_wdata),
    .sti_tready(sti_tready), .sti_tvalid(sti_tvalid), .sti_tevent(sti_tevent), .sti_tdata(sti_tdata),
    .sto_tready(sto_tready), .sto_tvalid(sto_tvalid), .sto_tlast(sto_tlast), .sto_tdata(sto_tdata),
    .sts_state(sts_state), .sts_trig(sts_trig), .sts_done(sts_done)
  );

  typedef struct {
    logic        wv;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [1:0]  ev;
    logic [31:0] id;
    logic        ordy;
    logic        xv;
    logic        xl;
    logic [31:0] xd;
    logic [2:0]  xs;
    logic        xt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic wv, input logic [1:0] wa, input logic [31:0] wd,
                              input logic iv, input logic [1:0] ev, input logic [31:0] id,
                              input logic ordy, input logic xv, input logic xl,
                              input logic [31:0] xd, input logic [2:0] xs, input logic xt);
    vec_t v;
    v.wv = wv; v.wa = wa; v.wd = wd; v.iv = iv; v.ev = ev; v.id = id; v.ordy = ordy;
    v.xv = xv; v.xl = xl; v.xd = xd; v.xs = xs; v.xt = xt;
    tbl.push_back(v);
  endfunction

  // bus write cycle without a sample; output is expected empty afterwards
  function automatic void vw(input logic [1:0] a, input logic [31:0] d, input logic [2:0] xs);
    add(1'b1, a, d, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, xs, 1'b0);
  endfunction

  // sample cycle with sto_tready=1; a forwarded beat carries the same data
  function automatic void vs(input logic [1:0] ev, input logic [31:0] id, input logic xv,
                             input logic xl, input logic [2:0] xs, input logic xt);
    add(1'b0, 2'd0, 32'h0, 1'b1, ev, id, 1'b1, xv, xl, id, xs, xt);
  endfunction

  task automatic cyc(input logic wv, input logic [1:0] wa, input logic [31:0] wd,
                     input logic iv, input logic [1:0] ev, input logic [31:0] id);
    bus_wvalid = wv; bus_waddr = {4'b0000, wa}; bus_wdata = wd;
    sti_tvalid = iv; sti_tevent = ev; sti_tdata = id;
    @(posedge clk);
    #1;
    bus_wvalid = 1'b0;
    sti_tvalid = 1'b0;
    sti_tevent = 2'b00;
  endtask

  // output monitor for the backpressure sequence
  logic        mon_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;
  logic [31:0] beat_d[$];
  logic        beat_l[$];
  int          trig_cnt = 0;

  // sample away from the active edge; inputs are stable from posedge+1 onward
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("hold.valid", {31'b0, sto_tvalid}, 32'd1);
        chk("hold.data", sto_tdata, prev_d);
        chk("hold.last", {31'b0, sto_tlast}, {31'b0, prev_l});
      end
      prev_stall = sto_tvalid & ~sto_tready;
      prev_d     = sto_tdata;
      prev_l     = sto_tlast;
      if (sto_tvalid && sto_tready) begin
        beat_d.push_back(sto_tdata);
        beat_l.push_back(sto_tlast);
        $display("[TB] beat data=%0h last=%0b", sto_tdata, sto_tlast);
      end
      if (sts_trig) trig_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus_wvalid = 1'b0; bus_waddr = '0; bus_wdata = '0;
    sti_tvalid = 1'b0; sti_tevent = '0; sti_tdata = '0;
    sto_tready = 1'b1;

    // ---------------- vector table ----------------
    // nominal capture: PRE=3 POST=2, trigger on sample 5
    vw(2'd1, 32'd3, S_I);
    vw(2'd2, 32'd2, S_I);
    add(1'b1, 2'd0, 32'd1, 1'b1, 2'b00, 32'hFF, 1'b1, 1'b0, 1'b0, 32'h0, S_F, 1'b0); // ARM; its sample is dropped
    vs(2'b00, 32'd0, 1, 0, S_F, 0);
    vs(2'b00, 32'd1, 1, 0, S_F, 0);
    vs(2'b00, 32'd2, 1, 0, S_A, 0);
    vs(2'b00, 32'd3, 1, 0, S_A, 0);
    vs(2'b00, 32'd4, 1, 0, S_A, 0);
    vs(2'b01, 32'd5, 1, 0, S_P, 1);
    vs(2'b00, 32'd6, 1, 0, S_P, 0);
    vs(2'b00, 32'd7, 1, 1, S_D, 0);
    vs(2'b00, 32'd8, 0, 0, S_D, 0);
    vs(2'b00, 32'd9, 0, 0, S_D, 0);
    vw(2'd0, 32'd2, S_I);
    // boundary counts: PRE=0 POST=0, trigger on first sample
    vw(2'd1, 32'd0, S_I);
    vw(2'd2, 32'd0, S_I);
    vw(2'd0, 32'd1, S_A);
    vs(2'b01, 32'hA5, 1, 1, S_D, 1);
    // early stop: POST=10, stop on third post sample
    vw(2'd2, 32'd10, S_D);
    vw(2'd0, 32'd1, S_A);
    vs(2'b01, 32'h10, 1, 0, S_P, 1);
    vs(2'b00, 32'h11, 1, 0, S_P, 0);
    vs(2'b00, 32'h12, 1, 0, S_P, 0);
    vs(2'b10, 32'h13, 1, 1, S_D, 0);
    // abort in POST with sample in the abort cycle: sample dropped
    vw(2'd0, 32'd1, S_A);
    vs(2'b01, 32'h20, 1, 0, S_P, 1);
    vs(2'b00, 32'h21, 1, 0, S_P, 0);
    add(1'b1, 2'd0, 32'd2, 1'b1, 2'b00, 32'h22, 1'b1, 1'b0, 1'b0, 32'h0, S_I, 1'b0);
    vs(2'b00, 32'h23, 0, 0, S_I, 0);
    // abort while the output is stalled: held beat still delivered
    vw(2'd0, 32'd1, S_A);
    vs(2'b01, 32'h30, 1, 0, S_P, 1);
    add(1'b1, 2'd0, 32'd2, 1'b1, 2'b00, 32'h31, 1'b0, 1'b1, 1'b0, 32'h30, S_I, 1'b0);
    add(1'b0, 2'd0, 32'd0, 1'b0, 2'b00, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, S_I, 1'b0);
    // commands: ARM+ABORT stays IDLE, ARM in ARMED ignored
    vw(2'd0, 32'd3, S_I);
    vw(2'd1, 32'd2, S_I);
    vw(2'd0, 32'd1, S_F);
    vs(2'b00, 32'h40, 1, 0, S_F, 0);
    vs(2'b00, 32'h41, 1, 0, S_A, 0);
    vw(2'd0, 32'd1, S_A);
    vs(2'b00, 32'h42, 1, 0, S_A, 0);
    vw(2'd0, 32'd2, S_I);

    // ---------------- reset state ----------------
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid", {31'b0, sto_tvalid}, 32'd0);
    chk("reset.last", {31'b0, sto_tlast}, 32'd0);
    chk("reset.data", sto_tdata, 32'd0);
    chk("reset.state", {29'b0, sts_state}, 32'd0);
    chk("reset.trig", {31'b0, sts_trig}, 32'd0);
    chk("reset.done", {31'b0, sts_done}, 32'd0);
    chk("reset.sti_tready", {31'b0, sti_tready}, 32'd1);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // ---------------- apply table ----------------
    for (int k = 0; k < tbl.size(); k++) begin
      sto_tready = tbl[k].ordy;
      cyc(tbl[k].wv, tbl[k].wa, tbl[k].wd, tbl[k].iv, tbl[k].ev, tbl[k].id);
      $display("[TB] vec %0d: state=%0d valid=%0b data=%0h last=%0b trig=%0b",
               k, sts_state, sto_tvalid, sto_tdata, sto_tlast, sts_trig);
      chk($sformatf("v%0d.state", k), {29'b0, sts_state}, {29'b0, tbl[k].xs});
      chk($sformatf("v%0d.trig", k), {31'b0, sts_trig}, {31'b0, tbl[k].xt});
      chk($sformatf("v%0d.done", k), {31'b0, sts_done}, {31'b0, (tbl[k].xs == S_D)});
      chk($sformatf("v%0d.valid", k), {31'b0, sto_tvalid}, {31'b0, tbl[k].xv});
      if (tbl[k].xv) begin
        chk($sformatf("v%0d.data", k), sto_tdata, tbl[k].xd);
        chk($sformatf("v%0d.last", k), {31'b0, sto_tlast}, {31'b0, tbl[k].xl});
      end
    end
    sto_tready = 1'b1;

    // ---------------- backpressure: sto_tready 1010... ----------------
    begin
      int  i;
      int  n;
      logic acc;
      cyc(1'b1, 2'd1, 32'd3, 1'b0, 2'b00, 32'h0);
      cyc(1'b1, 2'd2, 32'd2, 1'b0, 2'b00, 32'h0);
      cyc(1'b1, 2'd0, 32'd1, 1'b0, 2'b00, 32'h0);
      beat_d.delete();
      beat_l.delete();
      trig_cnt = 0;
      mon_en = 1'b1;
      i = 0;
      n = 0;
      while (i < 10 && n < 200) begin
        sto_tready = (n % 2 == 0);
        sti_tvalid = 1'b1;
        sti_tdata  = i;
        sti_tevent = (i == 5) ? 2'b01 : 2'b00;
        #1;
        acc = sti_tready;
        @(posedge clk);
        #1;
        if (acc) i++;
        n++;
      end
      if (n >= 200) chk("bp.timeout", 32'(i), 32'd10);
      sti_tvalid = 1'b0;
      sti_tevent = 2'b00;
      sto_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b0;
      chk("bp.beats", 32'(beat_d.size()), 32'd8);
      for (int j = 0; j < beat_d.size() && j < 8; j++) begin
        chk($sformatf("bp.data%0d", j), beat_d[j], 32'(j));
        chk($sformatf("bp.last%0d", j), {31'b0, beat_l[j]}, {31'b0, (j == 7)});
      end
      chk("bp.trig_pulses", 32'(trig_cnt), 32'd1);
      chk("bp.state", {29'b0, sts_state}, {29'b0, S_D});
    end

    // ---------------- asynchronous reset mid-POST ----------------
    cyc(1'b1, 2'd1, 32'd0, 1'b0, 2'b00, 32'h0);
    cyc(1'b1, 2'd2, 32'd5, 1'b0, 2'b00, 32'h0);
    cyc(1'b1, 2'd0, 32'd1, 1'b0, 2'b00, 32'h0);
    cyc(1'b0, 2'd0, 32'd0, 1'b1, 2'b01, 32'h60);
    sto_tready = 1'b0;
    cyc(1'b0, 2'd0, 32'd0, 1'b1, 2'b00, 32'h61);
    chk("arst.pre_state", {29'b0, sts_state}, {29'b0, S_P});
    chk("arst.pre_valid", {31'b0, sto_tvalid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("[TB] async reset: state=%0d valid=%0b data=%0h", sts_state, sto_tvalid, sto_tdata);
    chk("arst.valid", {31'b0, sto_tvalid}, 32'd0);
    chk("arst.last", {31'b0, sto_tlast}, 32'd0);
    chk("arst.data", sto_tdata, 32'd0);
    chk("arst.state", {29'b0, sts_state}, 32'd0);
    chk("arst.trig", {31'b0, sts_trig}, 32'd0);
    chk("arst.done", {31'b0, sts_done}, 32'd0);
    #2 rst = 1'b0;
    sto_tready = 1'b1;
    @(posedge clk);
    #1;
    // configuration returns to zero: ARM goes straight to ARMED, trigger ends capture
    cyc(1'b1, 2'd0, 32'd1, 1'b0, 2'b00, 32'h0);
    chk("arst.cfg_pre0", {29'b0, sts_state}, {29'b0, S_A});
    cyc(1'b0, 2'd0, 32'd0, 1'b1, 2'b01, 32'h70);
    chk("arst.cfg_post0_state", {29'b0, sts_state}, {29'b0, S_D});
    chk("arst.cfg_post0_last", {31'b0, sto_tlast}, 32'd1);
    chk("arst.cfg_post0_data", sto_tdata, 32'h70);

`ifdef TRIGGER_CAPTURE_CTRL_TIMEOUT_EN
    // ---------------- timeout force-trigger ----------------
    cyc(1'b1, 2'd3, 32'd4, 1'b0, 2'b00, 32'h0);
    cyc(1'b1, 2'd2, 32'd1, 1'b0, 2'b00, 32'h0);
    cyc(1'b1, 2'd0, 32'd1, 1'b0, 2'b00, 32'h0);
    chk("tmo.armed", {29'b0, sts_state}, {29'b0, S_A});
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 2'd0, 32'd0, 1'b1, 2'b00, 32'h80 + 32'(k));
      $display("[TB] tmo sample %0d: state=%0d trig=%0b", k, sts_state, sts_trig);
      chk($sformatf("tmo.trig%0d", k), {31'b0, sts_trig}, {31'b0, (k == 3)});
      chk($sformatf("tmo.state%0d", k), {29'b0, sts_state}, (k == 3) ? 32'(S_P) : 32'(S_A));
    end
    cyc(1'b0, 2'd0, 32'd0, 1'b1, 2'b00, 32'h84);
    chk("tmo.done", {29'b0, sts_state}, {29'b0, S_D});
    chk("tmo.last", {31'b0, sto_tlast}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trigger_capture_ctrl.md
# trigger_capture_ctrl

Capture sequencer between the trigger block's output stream and the sample memory writer. It arms on a bus command and forwards a pre-trigger fill of samples. It then waits for the trigger event, forwards a programmed number of post-trigger samples, and marks the final beat with `tlast`. Samples outside an active capture are consumed and dropped so the trigger pipeline never stalls.

## Interface
Parameters:
- `BAW`, 6: bus address width
- `BDW`, 32: bus data width
- `SDW`, 32: sample data width
- `SEW`, 2: sample event width (bit0 trigger, bit1 stop)
- `CW`, 32: pre/post/timeout counter width (CW ≤ BDW)

Ports:
- `clk`  in  1: clock
- `rst`  in  1: reset; asynchronous, active-high
- `bus_wready`  out  1: constant 1
- `bus_wvalid`  in  1: bus write valid
- `bus_waddr`  in  BAW: register address (bits [1:0] decoded)
- `bus_wdata`  in  BDW: write data
- `sti_tready`  out  1: input ready
- `sti_tvalid`  in  1: input valid
- `sti_tevent`  in  SEW: per-sample events
- `sti_tdata`  in  SDW: sample
- `sto_tready`  in  1: output ready
- `sto_tvalid`  out  1: output valid
- `sto_tlast`  out  1: last beat of the capture
- `sto_tdata`  out  SDW: sample
- `sts_state`  out  3: current state encoding
- `sts_trig`  out  1: one-cycle pulse when the trigger is accepted
- `sts_done`  out  1: high while in DONE

## Operation
- Registers are written on `bus_wvalid`:
  - addr 0 CTRL: bit0 ARM, bit1 ABORT. These are commands, not stored.
  - addr 1 PRE: `cfg_pre[CW-1:0]`.
  - addr 2 POST: `cfg_post[CW-1:0]`.
  - addr 3 TIMEOUT: `cfg_tmo[CW-1:0]`; present only with the macro.
- PRE, POST and TIMEOUT reset to 0.
- States: IDLE=0, FILL=1, ARMED=2, POST=3, DONE=4.
- IDLE/DONE:
  - Input transfers are accepted and discarded.
  - ARM goes to FILL when `cfg_pre`≠0, otherwise to ARMED.
  - ARM in any other state is ignored.
- FILL:
  - Each transfer is forwarded and increments `cnt`.
  - The state moves to ARMED on the transfer where `cnt == cfg_pre-1`.
  - Trigger events during FILL are ignored.
- ARMED:
  - Samples are forwarded.
  - The first transfer with `tevent[0]`=1 is the trigger sample. It pulses `sts_trig` and clears `cnt`.
  - If `cfg_post`=0 or `tevent[1]`=1, the trigger beat gets `tlast`=1 and the state goes to DONE. Otherwise the state goes to POST.
  - A stop event (`tevent[1]`) without a trigger in ARMED is ignored.
- POST:
  - Each transfer is forwarded and increments `cnt`.
  - The beat where `cnt == cfg_post-1` or `tevent[1]`=1 gets `tlast`=1, and the state goes to DONE.
- ABORT in any state goes to IDLE next cycle and clears `cnt`.
  - A beat already in the output register is still delivered unchanged.
  - The sample transferred in the abort cycle is dropped.
- ARM and ABORT written in the same cycle: ABORT wins.
- Register writes during a capture take effect immediately. The team accepts this; software writes them only in IDLE/DONE.
- Counters compare with equality. `cfg_pre` = 2^CW-1 is legal; there is no wrap-around because the state exits at equality.

## Timing
- Reset values: `sto_tvalid`=0, `sto_tlast`=0, `sto_tdata`=0, `sts_state`=IDLE, `sts_trig`=0, `sts_done`=0, `cnt`=0.
- Output stage:
  - Single registered stage, latency 1 cycle from input transfer to `sto_tvalid`.
  - `sti_tready = sto_tready | ~sto_tvalid` in forwarding states (FILL, ARMED, POST).
  - `sti_tready` = 1 in IDLE/DONE.
- `sto_tdata` and `sto_tlast` hold stable while `sto_tvalid & ~sto_tready`.
- Back-to-back transfers sustain 1 sample/clock.
- A bus command takes effect on the next clock edge. The first forwarded sample is the one transferred in the cycle after the ARM write.
- `sts_trig` asserts in the cycle after the trigger sample transfer. `sts_state` and `sts_done` update on the same edge.

## Configuration
- Macro `TRIGGER_CAPTURE_CTRL_TIMEOUT_EN`.
- When defined:
  - Register addr 3 exists.
  - In ARMED, a timeout counter increments per transfer.
  - If `cfg_tmo`≠0 and the counter reaches `cfg_tmo-1`, that sample is treated as the trigger sample (force-trigger), including `sts_trig`.
  - The timeout counter is cleared on entry to ARMED.
  - `cfg_tmo`=0 disables the timeout.
- When undefined:
  - Writes to addr 3 are ignored.
  - ARMED waits indefinitely for `tevent[0]`.

## Test plan
- Nominal capture: PRE=3, POST=2, ARM, samples 0..9 with `tevent[0]` on sample 5 -> output 0,1,2,3,4,5,6,7; `tlast` on 7; `sts_trig` one pulse; DONE; samples 8,9 dropped.
- Boundary counts: PRE=0, POST=0, ARM, trigger on the first sample 0xA5 -> single beat 0xA5 with `tlast`=1; state goes IDLE→ARMED→DONE.
- Backpressure: `sto_tready` toggling 1010…, same stimulus as the nominal capture -> identical output sequence, no loss or duplication, data stable while stalled.
- Early stop and abort:
  - POST=10, stop event on the 3rd post sample -> `tlast` on that beat, DONE.
  - Separate run with ABORT in POST -> IDLE, following samples dropped.
- Commands and reset:
  - ARM+ABORT in the same write -> stays IDLE.
  - ARM in ARMED -> ignored.
  - Asynchronous `rst` mid-POST -> all outputs at reset values immediately.
- Timeout (macro defined): TMO=4, no trigger events -> 4th ARMED sample forced as trigger; `sts_trig` pulses.
